// File: rtl/tap_unlock_ctrl_if.sv
// Key-entry and status bundle between a debug host/TAP and tap_unlock_ctrl.
// The master drives the key stream and relock request; the slave (controller) returns lock status.
interface tap_unlock_ctrl_if #(
    parameter int TRIES_W = 2
);
    logic               key_shift_i;
    logic               key_bit_i;
    logic               key_update_i;
    logic               relock_i;
    logic               lock_o;
    logic               lockout_o;
    logic               fail_o;
    logic [TRIES_W-1:0] tries_o;
    logic [2:0]         state_o;

    modport master (
        output key_shift_i, key_bit_i, key_update_i, relock_i,
        input  lock_o, lockout_o, fail_o, tries_o, state_o
    );

    modport slave (
        input  key_shift_i, key_bit_i, key_update_i, relock_i,
        output lock_o, lockout_o, fail_o, tries_o, state_o
    );
endinterface

// File: rtl/tap_unlock_ctrl.sv
// Debug-TAP unlock sequencer: serial key capture, compare, failure counting and lockout.
// Define TAP_UNLOCK_STICKY_EN to make LOCKOUT terminal (exit only through rst_i).
module tap_unlock_ctrl #(
    parameter int               KEY_W       = 32,
    parameter logic [KEY_W-1:0] KEY_VALUE   = 32'hA5C3_5A3C,
    parameter int               MAX_TRIES   = 3,
    parameter int               LOCKOUT_CYC = 1024
) (
    input  logic          tck_i,
    input  logic          rst_i,
    tap_unlock_ctrl_if.slave bus
);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int CNT_W   = $clog2(KEY_W + 2);

    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(KEY_W + 1);
    localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_LOCKED   = 3'd0,
        S_CHECK    = 3'd1,
        S_UNLOCKED = 3'd2,
        S_LOCKOUT  = 3'd3
    } state_t;

    state_t             state, state_nxt;
    logic [KEY_W-1:0]   key_sr;
    logic [CNT_W-1:0]   bitcnt;
    logic [TRIES_W-1:0] tries;
    logic               fail_q;
    logic               key_ok;
    logic               last_try;
    logic               lo_done;
    logic               lock;
    logic               lockout;

    // Bit counter parks one past the key length so over-length entries stay distinguishable.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

    assign key_ok   = (key_sr == KEY_VALUE) && (bitcnt == CNT_FULL);
    assign last_try = (tries + TRIES_W'(1)) == TRIES_MAX;

`ifdef TAP_UNLOCK_STICKY_EN
    assign lo_done = 1'b0;
`else
    localparam int LO_W = $clog2(LOCKOUT_CYC + 1);
    logic [LO_W-1:0] lo_cnt;

    assign lo_done = (lo_cnt == '0);

    // Loaded with LOCKOUT_CYC-1 so LOCKOUT occupies exactly LOCKOUT_CYC cycles including zero.
    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            lo_cnt <= '0;
        end else if (state == S_CHECK && !key_ok && last_try) begin
            lo_cnt <= LO_W'(LOCKOUT_CYC - 1);
        end else if (state == S_LOCKOUT && !lo_done) begin
            lo_cnt <= lo_cnt - LO_W'(1);
        end
    end
`endif

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) state <= S_LOCKED;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOCKED:   if (!bus.relock_i && bus.key_update_i) state_nxt = S_CHECK;
            S_CHECK: begin
                if (key_ok)        state_nxt = S_UNLOCKED;
                else if (last_try) state_nxt = S_LOCKOUT;
                else               state_nxt = S_LOCKED;
            end
            S_UNLOCKED: if (bus.relock_i) state_nxt = S_LOCKED;
            S_LOCKOUT:  if (lo_done) state_nxt = S_LOCKED;
            default:    state_nxt = S_LOCKED;
        endcase
    end

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            key_sr <= '0;
            bitcnt <= '0;
            tries  <= '0;
            fail_q <= 1'b0;
        end else begin
            fail_q <= (state == S_CHECK) && !key_ok;
            case (state)
                S_LOCKED: begin
                    // Relock beats update, and update beats a same-cycle shift.
                    if (bus.relock_i) begin
                        key_sr <= '0;
                        bitcnt <= '0;
                    end else if (!bus.key_update_i && bus.key_shift_i) begin
                        key_sr <= {bus.key_bit_i, key_sr[KEY_W-1:1]};
                        bitcnt <= sat_inc(bitcnt);
                    end
                end
                S_CHECK: begin
                    key_sr <= '0;
                    bitcnt <= '0;
                    tries  <= key_ok ? '0 : tries + TRIES_W'(1);
                end
                S_LOCKOUT: if (lo_done) tries <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        lock    = 1'b1;
        lockout = 1'b0;
        case (state)
            S_UNLOCKED: lock    = 1'b0;
            S_LOCKOUT:  lockout = 1'b1;
            default: ;
        endcase
    end

    assign bus.lock_o    = lock;
    assign bus.lockout_o = lockout;
    assign bus.fail_o    = fail_q;
    assign bus.tries_o   = tries;
    assign bus.state_o   = state;
endmodule

// File: tb/tb_tap_unlock_ctrl.sv
// Scoreboard bench for tap_unlock_ctrl: each key submission queues its expected outcome,
// which is checked the cycle after the controller leaves CHECK.
module tb_tap_unlock_ctrl;
    localparam logic [31:0] KEY = 32'hA5C3_5A3C;

    typedef struct {
        logic       lock;
        logic       lockout;
        logic       fail;
        logic [1:0] tries;
        logic [2:0] st;
    } exp_t;

    logic tck = 1'b0;
    logic rst = 1'b1;

    tap_unlock_ctrl_if #(.TRIES_W(2)) bus ();

    tap_unlock_ctrl #(
        .KEY_W(32), .KEY_VALUE(KEY), .MAX_TRIES(3), .LOCKOUT_CYC(1024)
    ) dut (
        .tck_i(tck),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 tck = ~tck;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [31:0] m_sr = '0;
    int          m_cnt = 0;
    int          m_tries = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output side of the scoreboard: the cycle after CHECK carries the verdict.
    initial begin
        logic prev_chk;
        exp_t e;
        prev_chk = 1'b0;
        forever begin
            @(negedge tck);
            if (rst) begin
                prev_chk = 1'b0;
            end else begin
                if (prev_chk) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_lock",    32'(bus.lock_o),    32'(e.lock));
                        chk("sb_lockout", 32'(bus.lockout_o), 32'(e.lockout));
                        chk("sb_fail",    32'(bus.fail_o),    32'(e.fail));
                        chk("sb_tries",   32'(bus.tries_o),   32'(e.tries));
                        chk("sb_state",   32'(bus.state_o),   32'(e.st));
                    end
                end
                prev_chk = (bus.state_o == 3'd1);
            end
        end
    end

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic model_clear();
        m_sr  = '0;
        m_cnt = 0;
    endtask

    task automatic shift_bits(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.key_shift_i = 1'b1;
            bus.key_bit_i   = v[i];
            tick();
            m_sr = {v[i], m_sr[31:1]};
            if (m_cnt < 33) m_cnt++;
        end
        bus.key_shift_i = 1'b0;
        bus.key_bit_i   = 1'b0;
    endtask

    // Input side of the scoreboard: verdict derived from the bench's own key model.
    task automatic update(input logic with_shift, input logic b);
        exp_t e;
        bus.key_update_i = 1'b1;
        bus.key_shift_i  = with_shift;
        bus.key_bit_i    = b;
        tick();
        bus.key_update_i = 1'b0;
        bus.key_shift_i  = 1'b0;
        bus.key_bit_i    = 1'b0;
        if (m_sr == KEY && m_cnt == 32) begin
            m_tries = 0;
            e = '{lock: 1'b0, lockout: 1'b0, fail: 1'b0, tries: 2'd0, st: 3'd2};
        end else begin
            m_tries++;
            if (m_tries == 3)
                e = '{lock: 1'b1, lockout: 1'b1, fail: 1'b1, tries: 2'd3, st: 3'd3};
            else
                e = '{lock: 1'b1, lockout: 1'b0, fail: 1'b1, tries: 2'(m_tries), st: 3'd0};
        end
        sb.push_back(e);
        model_clear();
        tick();
    endtask

    task automatic relock_pulse(input string tag);
        bus.relock_i = 1'b1;
        tick();
        bus.relock_i = 1'b0;
        model_clear();
        @(negedge tck);
        chk({tag, "_lock"},  32'(bus.lock_o),  32'd1);
        chk({tag, "_state"}, 32'(bus.state_o), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge tck);
        #1;
        rst = 1'b1;
        #2;
        chk({tag, "_lock"},    32'(bus.lock_o),    32'd1);
        chk({tag, "_lockout"}, 32'(bus.lockout_o), 32'd0);
        chk({tag, "_fail"},    32'(bus.fail_o),    32'd0);
        chk({tag, "_tries"},   32'(bus.tries_o),   32'd0);
        chk({tag, "_state"},   32'(bus.state_o),   32'd0);
        bus.key_shift_i  = 1'b0;
        bus.key_update_i = 1'b0;
        bus.relock_i     = 1'b0;
        bus.key_bit_i    = 1'b0;
        repeat (2) @(negedge tck);
        rst = 1'b0;
        model_clear();
        m_tries = 0;
        tick();
    endtask

    task automatic three_fails();
        shift_bits({32'h0, KEY ^ 32'h0000_0001}, 32);
        update(1'b0, 1'b0);
        shift_bits({32'h0, KEY ^ 32'h8000_0000}, 32);
        update(1'b0, 1'b0);
        shift_bits(64'h0, 32);
        update(1'b0, 1'b0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;
        bus.key_shift_i  = 1'b0;
        bus.key_bit_i    = 1'b0;
        bus.key_update_i = 1'b0;
        bus.relock_i     = 1'b0;

        do_reset("rst0");

        // Correct key unlocks two cycles after update.
        shift_bits({32'h0, KEY}, 32);
        update(1'b0, 1'b0);
        relock_pulse("relock1");

        // Under- and over-length entries of the right key.
        shift_bits({32'h0, KEY}, 31);
        update(1'b0, 1'b0);
        shift_bits({32'h1, KEY}, 33);
        update(1'b0, 1'b0);
        shift_bits({32'h0, KEY}, 32);
        update(1'b0, 1'b0);
        relock_pulse("relock2");

        // Same-cycle shift and update: the 32nd bit is dropped.
        shift_bits({32'h0, KEY}, 31);
        update(1'b1, KEY[31]);
        // Relock mid-shift discards the partial key.
        shift_bits(64'h3FF, 10);
        relock_pulse("relock_mid");
        shift_bits({32'h0, KEY}, 32);
        update(1'b0, 1'b0);
        relock_pulse("relock3");

        three_fails();
`ifdef TAP_UNLOCK_STICKY_EN
        repeat (5000) @(negedge tck);
        chk("sticky_lockout", 32'(bus.lockout_o), 32'd1);
        chk("sticky_state",   32'(bus.state_o),   32'd3);
        do_reset("rst_sticky");
`else
        w = 0;
        @(negedge tck);
        while (!bus.lockout_o && w < 10) begin
            @(negedge tck);
            w++;
        end
        chk("lockout_entry", 32'(bus.lockout_o), 32'd1);
        n = 0;
        while (bus.lockout_o && n < 3000) begin
            n++;
            if (n == 100) begin
                bus.key_update_i = 1'b1;
                bus.key_shift_i  = 1'b1;
                bus.relock_i     = 1'b1;
            end
            if (n == 103) begin
                bus.key_update_i = 1'b0;
                bus.key_shift_i  = 1'b0;
                bus.relock_i     = 1'b0;
            end
            @(negedge tck);
        end
        chk("lockout_len",   32'(n),             32'd1024);
        chk("post_lo_state", 32'(bus.state_o),   32'd0);
        chk("post_lo_tries", 32'(bus.tries_o),   32'd0);
        chk("post_lo_lock",  32'(bus.lock_o),    32'd1);
        m_tries = 0;
`endif

        // Reset mid-shift, then a clean full key still unlocks.
        shift_bits({32'h0, KEY}, 16);
        do_reset("rst_shift");
        shift_bits({32'h0, KEY}, 32);
        update(1'b0, 1'b0);
        relock_pulse("relock4");

        // Reset part-way through a lockout.
        three_fails();
        repeat (50) @(negedge tck);
        chk("mid_lockout", 32'(bus.lockout_o), 32'd1);
        do_reset("rst_lockout");

        repeat (3) @(negedge tck);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
